// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind the CPU memory stage.
// Writes commit in one cycle; reads complete READ_LATENCY cycles after
// acceptance with a single-cycle `valid` pulse.
//
// Optional build macro: DMEM_ALIGN_CHECK_EN. When it is defined, misaligned
// accesses are flagged, writes are dropped, and reads return 32'hDEADBEEF.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   memrd           read request, held by the CPU until `valid`
//   memwr           single-cycle write request
//   halt            blocks acceptance of new requests
//   Addr            byte address; word index is Addr[AW+1:2]
//   MemDataIn       write data
//   MemOut          registered read data, holds its value outside `valid`
//   valid           one-cycle read completion pulse (high in DONE)
//   CPUValid        IDLE and not halted, so a request can be accepted
//   err             sticky protocol/alignment error, cleared by rst only
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS  = 4096,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memrd,
    input  logic        memwr,
    input  logic        halt,
    input  logic [31:0] Addr,
    input  logic [31:0] MemDataIn,
    output logic [31:0] MemOut,
    output logic        valid,
    output logic        CPUValid,
    output logic        err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam int unsigned CW       = 4;
    localparam logic [31:0] BAD_WORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic           misal_q, misal_d;
    logic [31:0]    memout_q, memout_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;

    logic [31:0]    mem_q [DEPTH_WORDS];
    logic           wr_en;
    logic [AW-1:0]  addr_idx;
    logic           addr_misal;
    logic           unused_addr;

    // Upper address bits wrap away; they intentionally have no effect.
    assign addr_idx    = Addr[AW+1:2];
    assign unused_addr = ^{Addr[31:AW+2], Addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign addr_misal = (Addr[1:0] != 2'b00);
`else
    assign addr_misal = 1'b0;
`endif

    // Next-state, datapath and error logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        misal_d  = misal_q;
        memout_d = memout_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        wr_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!halt) begin
                    if (memrd) begin
                        // A read wins over a simultaneous write; the write is dropped.
                        idx_d   = addr_idx;
                        misal_d = addr_misal;
                        cnt_d   = CW'(READ_LATENCY - 1);
                        if (memwr || addr_misal) begin
                            err_d = 1'b1;
                        end
                        if (READ_LATENCY == 1) begin
                            state_d  = S_DONE;
                            valid_d  = 1'b1;
                            memout_d = addr_misal ? BAD_WORD : mem_q[addr_idx];
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else if (memwr) begin
                        if (addr_misal) begin
                            err_d = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                // valid and MemOut are loaded on the edge that enters DONE.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    memout_d = misal_q ? BAD_WORD : mem_q[idx_q];
                end
            end
            S_DONE: begin
                // memrd is still high for this request; leaving DONE avoids re-accepting it.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Writes outside IDLE are protocol violations and are ignored.
        if (memwr && (state_q != S_IDLE)) begin
            err_d = 1'b1;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            misal_q  <= 1'b0;
            memout_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            misal_q  <= misal_d;
            memout_q <= memout_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr_idx] <= MemDataIn;
        end
    end

    assign MemOut   = memout_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign CPUValid = (state_q == S_IDLE) && !halt;

endmodule
